// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, defaults and bank-select type for the layer datapath
package nn_pkg;

   localparam int FLOAT_W  = 32;
   localparam int N_IN_DEF = 10;

   typedef enum logic {
      B0 = 1'b0,
      B1 = 1'b1
   } bank_sel_t;

   function automatic bank_sel_t other_bank(input bank_sel_t b);
      return (b == B0) ? B1 : B0;
   endfunction

endpackage

// File: rtl/layer_act_loader_if.sv
// rtl/layer_act_loader_if.sv - activation input stream plus parallel vector output bundle
interface layer_act_loader_if
   import nn_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int FW   = FLOAT_W
);

   logic                 s_valid;
   logic                 s_ready;
   logic [FW-1:0]        s_data;
   logic                 s_last;
   logic                 m_valid;
   logic                 m_ready;
   logic [N_IN*FW-1:0]   m_act;
   logic                 frame_err;

   // slave is the loader; master is the upstream source and the consuming layer
   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_act, frame_err
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_act, frame_err
   );

endinterface

// File: rtl/act_bank.sv
// rtl/act_bank.sv - one N_IN x FW activation register file with its full flag
module act_bank
   import nn_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int FW   = FLOAT_W,
   parameter int IW   = $clog2(N_IN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IW-1:0]       idx,
   input  logic [FW-1:0]       data,
   input  logic                set_full,
   input  logic                clr_full,
   output logic                full,
   output logic [N_IN*FW-1:0]  rd_vec
);

   logic [FW-1:0] mem [N_IN];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++) begin
            mem[i] <= '0;
         end
         full <= 1'b0;
      end else begin
         if (we) begin
            mem[idx] <= data;
         end
         if (set_full) begin
            full <= 1'b1;
         end else if (clr_full) begin
            full <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < N_IN; g++) begin : g_flat
      assign rd_vec[FW*g +: FW] = mem[g];
   end

endmodule

// File: rtl/layer_act_loader.sv
// rtl/layer_act_loader.sv - ping-pong loader assembling streamed float activations into a layer input vector
module layer_act_loader
   import nn_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int FW   = FLOAT_W
) (
   input  logic               clk,
   input  logic               rst,
   layer_act_loader_if.slave  bus
);

   localparam int            IW       = $clog2(N_IN);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

   logic [IW-1:0]       wr_cnt;
   bank_sel_t           wr_sel;
   bank_sel_t           rd_sel;
   logic                rdy_en;
   logic                full0, full1;
   logic [N_IN*FW-1:0]  vec0, vec1;
   logic                wr_full;
   logic                accept, at_last, complete, bad_frame, consume;

   // rdy_en holds s_ready low through reset and for the first cycle after it
   assign wr_full     = (wr_sel == B1) ? full1 : full0;
   assign bus.s_ready = rdy_en && !wr_full;
   assign bus.m_valid = (rd_sel == B1) ? full1 : full0;
   assign bus.m_act   = (rd_sel == B1) ? vec1 : vec0;

   assign accept    = bus.s_valid && bus.s_ready;
   assign at_last   = (wr_cnt == LAST_IDX);
   assign complete  = accept && at_last && bus.s_last;
   assign bad_frame = accept && (at_last != bus.s_last);
   assign consume   = bus.m_valid && bus.m_ready;

   act_bank #(.N_IN(N_IN), .FW(FW), .IW(IW)) u_bank0 (
      .clk      (clk),
      .rst      (rst),
      .we       (accept && (wr_sel == B0)),
      .idx      (wr_cnt),
      .data     (bus.s_data),
      .set_full (complete && (wr_sel == B0)),
      .clr_full (consume && (rd_sel == B0)),
      .full     (full0),
      .rd_vec   (vec0)
   );

   act_bank #(.N_IN(N_IN), .FW(FW), .IW(IW)) u_bank1 (
      .clk      (clk),
      .rst      (rst),
      .we       (accept && (wr_sel == B1)),
      .idx      (wr_cnt),
      .data     (bus.s_data),
      .set_full (complete && (wr_sel == B1)),
      .clr_full (consume && (rd_sel == B1)),
      .full     (full1),
      .rd_vec   (vec1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt        <= '0;
         wr_sel        <= B0;
         rd_sel        <= B0;
         rdy_en        <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         rdy_en        <= 1'b1;
         bus.frame_err <= bad_frame;
         if (accept) begin
            wr_cnt <= (complete || bad_frame) ? '0 : wr_cnt + IW'(1);
         end
         if (complete) begin
            wr_sel <= other_bank(wr_sel);
         end
         if (consume) begin
            rd_sel <= other_bank(rd_sel);
         end
      end
   end

endmodule

// File: tb/tb_layer_act_loader.sv
// tb/tb_layer_act_loader.sv - directed scoreboard bench for layer_act_loader
module tb_layer_act_loader;
   import nn_pkg::*;

   localparam int N  = N_IN_DEF;
   localparam int FW = FLOAT_W;
   localparam int VW = N * FW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   layer_act_loader_if #(.N_IN(N), .FW(FW)) bus ();

   layer_act_loader #(.N_IN(N), .FW(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks     = 0;
   int errors     = 0;
   int consumes   = 0;
   int err_pulses = 0;
   logic [VW-1:0] sb [$];

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] build(input logic [FW-1:0] base);
      logic [VW-1:0] v = '0;
      for (int i = 0; i < N; i++) v[FW*i +: FW] = base + FW'(i);
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.frame_err === 1'b1) err_pulses++;
         if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            consumes++;
            chk("sb_nonempty", VW'(sb.size() != 0), VW'(1));
            if (sb.size() != 0) chk("vector_order", bus.m_act, sb.pop_front());
         end
      end
   end

   task automatic send(input logic [FW-1:0] d, input logic l, output int stalls);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      while (bus.s_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("send_timeout", VW'(n), VW'(0));
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      stalls = n;
   endtask

   task automatic send_frame(input logic [FW-1:0] base, output int stalls);
      int s;
      stalls = 0;
      sb.push_back(build(base));
      for (int i = 0; i < N; i++) begin
         send(base + FW'(i), (i == N - 1), s);
         stalls += s;
      end
   endtask

   task automatic pulse_ready();
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (bus.m_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, VW'(bus.m_valid), VW'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st, tot, c0, e0;
      logic stable;
      logic [VW-1:0] exp;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", VW'(bus.s_ready), VW'(0));
      chk("rst_m_valid", VW'(bus.m_valid), VW'(0));
      chk("rst_m_act", bus.m_act, VW'(0));
      chk("rst_frame_err", VW'(bus.frame_err), VW'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("ready_low_first_cycle", VW'(bus.s_ready), VW'(0));
      @(posedge clk); #1;
      chk("ready_rises", VW'(bus.s_ready), VW'(1));

      // single frame, held while not consumed
      send_frame(32'h3F80_0000, st);
      exp = build(32'h3F80_0000);
      chk("single_m_valid", VW'(bus.m_valid), VW'(1));
      chk("single_m_act", bus.m_act, exp);
      chk("single_s_ready", VW'(bus.s_ready), VW'(1));
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.m_act !== exp || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b1) stable = 1'b0;
      end
      chk("single_hold_stable", VW'(stable), VW'(1));
      pulse_ready();
      chk("single_consumed", VW'(bus.m_valid), VW'(0));

      // backpressure: two frames fill both banks, third stalls until a consume
      send_frame(32'h4000_0000, st);
      send_frame(32'h4040_0000, st);
      chk("bp_both_full_ready", VW'(bus.s_ready), VW'(0));
      fork
         send_frame(32'h4080_0000, st);
         begin
            repeat (5) @(posedge clk);
            #1;
            chk("bp_still_stalled", VW'(bus.s_ready), VW'(0));
            chk("bp_first_held", bus.m_act, build(32'h4000_0000));
            pulse_ready();
         end
      join
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      chk("bp_all_delivered", VW'(sb.size()), VW'(0));
      chk("bp_drained", VW'(bus.m_valid), VW'(0));

      // continuous stream with an always-ready layer
      bus.m_ready = 1'b1;
      c0 = consumes;
      tot = 0;
      for (int f = 0; f < 5; f++) begin
         send_frame(32'h4100_0000 + FW'(f * 16), st);
         tot += st;
      end
      @(posedge clk); #1;
      chk("stream_no_stalls", VW'(tot), VW'(0));
      chk("stream_vectors", VW'(consumes - c0), VW'(5));

      // framing error A: early s_last
      c0 = consumes;
      e0 = err_pulses;
      for (int i = 0; i < 5; i++) send(32'h5000_0000 + FW'(i), (i == 4), st);
      chk("errA_pulse", VW'(bus.frame_err), VW'(1));
      @(posedge clk); #1;
      chk("errA_one_cycle", VW'(bus.frame_err), VW'(0));
      chk("errA_no_vector", VW'(consumes - c0), VW'(0));
      send_frame(32'h5100_0000, st);
      @(posedge clk); #1;
      chk("errA_next_frame", VW'(consumes - c0), VW'(1));
      chk("errA_pulse_count", VW'(err_pulses - e0), VW'(1));

      // framing error B: missing s_last on the final word
      c0 = consumes;
      e0 = err_pulses;
      for (int i = 0; i < N; i++) send(32'h5200_0000 + FW'(i), 1'b0, st);
      chk("errB_pulse", VW'(bus.frame_err), VW'(1));
      send_frame(32'h5300_0000, st);
      @(posedge clk); #1;
      chk("errB_next_frame", VW'(consumes - c0), VW'(1));
      chk("errB_pulse_count", VW'(err_pulses - e0), VW'(1));
      bus.m_ready = 1'b0;

      // simultaneous completion and consume
      send_frame(32'h6000_0000, st);
      sb.push_back(build(32'h6100_0000));
      for (int i = 0; i < N - 1; i++) send(32'h6100_0000 + FW'(i), 1'b0, st);
      bus.m_ready = 1'b1;
      send(32'h6100_0000 + FW'(N - 1), 1'b1, st);
      bus.m_ready = 1'b0;
      chk("simul_m_valid", VW'(bus.m_valid), VW'(1));
      chk("simul_m_act", bus.m_act, build(32'h6100_0000));
      chk("simul_s_ready", VW'(bus.s_ready), VW'(1));
      pulse_ready();
      chk("simul_drained", VW'(sb.size()), VW'(0));

      // reset mid-frame with a vector pending
      send_frame(32'h7000_0000, st);
      for (int i = 0; i < 6; i++) send(32'h7100_0000 + FW'(i), 1'b0, st);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_m_valid", VW'(bus.m_valid), VW'(0));
      chk("mid_rst_s_ready", VW'(bus.s_ready), VW'(0));
      chk("mid_rst_m_act", bus.m_act, VW'(0));
      sb.delete();
      rst = 1'b0;
      send_frame(32'h7200_0000, st);
      wait_valid("post_rst_valid");
      chk("post_rst_m_act", bus.m_act, build(32'h7200_0000));
      pulse_ready();
      chk("final_sb_empty", VW'(sb.size()), VW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
